// File: rtl/lut_eval_pkg.sv
// lut_eval_pkg: shared types and helpers for the reprogrammable LUT evaluator.
//   ld_state_e  - loader FSM state (RUN, LOAD)
//   calc_depth  - number of truth-table entries for a given input count
package lut_eval_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    LOAD = 1'b1
  } ld_state_e;

  // Truth-table depth for a width-input Boolean function.
  function automatic int calc_depth(input int width);
    return 32'sd1 << width;
  endfunction

endpackage

// File: rtl/lut_loader.sv
// lut_loader: bit-serial truth-table loader with atomic commit.
//   clk, reset_n   - clock, asynchronous active-low reset
//   cfg_start      - one-cycle load request (ignored while loading)
//   cfg_bit        - serial table bit, entry 0 first
//   cfg_valid      - qualifies cfg_bit (ignored while idle unless with cfg_start)
//   cfg_busy       - registered, high while a load is in progress
//   cfg_done       - registered, one-cycle pulse after the commit edge
//   commit         - combinational strobe: the table must take new_table this edge
//   new_table      - complete table including the bit accepted this cycle
module lut_loader
  import lut_eval_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = calc_depth(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_start,
  input  logic             cfg_bit,
  input  logic             cfg_valid,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             commit,
  output logic [DEPTH-1:0] new_table
);

  localparam logic [WIDTH-1:0] IDX_LAST = WIDTH'(DEPTH - 1);

  ld_state_e        state_r;
  ld_state_e        state_nxt_s;
  logic [WIDTH-1:0] idx_r;
  logic [DEPTH-1:0] shadow_r;
  logic             busy_r;
  logic             done_r;

  logic             accept_s;
  logic [WIDTH-1:0] idx_eff_s;
  logic [DEPTH-1:0] shadow_eff_s;
  logic [DEPTH-1:0] table_nxt_s;
  logic             commit_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;

  // Bit acceptance and shadow merge; a start with valid counts as entry 0
  // of a freshly cleared shadow, so the idle-state view is index 0 / all zero.
  always_comb begin
    accept_s     = 1'b0;
    idx_eff_s    = '0;
    shadow_eff_s = '0;
    case (state_r)
      RUN: begin
        accept_s     = cfg_valid & cfg_start;
        idx_eff_s    = '0;
        shadow_eff_s = '0;
      end
      LOAD: begin
        accept_s     = cfg_valid;
        idx_eff_s    = idx_r;
        shadow_eff_s = shadow_r;
      end
      default: begin
        accept_s     = 1'b0;
        idx_eff_s    = '0;
        shadow_eff_s = '0;
      end
    endcase

    table_nxt_s = shadow_eff_s;
    if (accept_s) begin
      table_nxt_s[idx_eff_s] = cfg_bit;
    end else begin
      table_nxt_s = shadow_eff_s;
    end

    commit_s = accept_s && (idx_eff_s == IDX_LAST);
  end

  // Loader state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a start that also commits (single-entry table) stays in RUN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (cfg_start && !commit_s) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      LOAD: begin
        if (commit_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Output decode; busy and done are registered below so they fall/rise together.
  always_comb begin
    busy_nxt_s = (state_nxt_s == LOAD);
    done_nxt_s = commit_s;
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Bit index and shadow register; cleared on commit so the next load starts clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r    <= '0;
      shadow_r <= '0;
    end else if (commit_s) begin
      idx_r    <= '0;
      shadow_r <= '0;
    end else if (accept_s) begin
      idx_r    <= idx_eff_s + WIDTH'(1);
      shadow_r <= table_nxt_s;
    end else if ((state_r == RUN) && cfg_start) begin
      idx_r    <= '0;
      shadow_r <= '0;
    end else begin
      idx_r    <= idx_r;
      shadow_r <= shadow_r;
    end
  end

  assign commit    = commit_s;
  assign new_table = table_nxt_s;
  assign cfg_busy  = busy_r;
  assign cfg_done  = done_r;

endmodule

// File: rtl/lut_eval.sv
// lut_eval: registered, reprogrammable WIDTH-input Boolean function.
//   clk, reset_n       - clock, asynchronous active-low reset
//   in, in_valid       - function inputs and qualifier
//   y, y_valid         - registered result and one-cycle new-result flag
//   cfg_start/bit/valid- bit-serial table load (entry 0 first)
//   cfg_busy, cfg_done - load in progress / one-cycle commit pulse
//   hit_clr            - synchronous clear of the hit counter
//   hit_count          - saturating count of evaluations returning 1
// Build option: define HIT_COUNT_EN to include the hit counter and the
// hit_count port; otherwise hit_clr is accepted and ignored.
module lut_eval
  import lut_eval_pkg::*;
#(
  parameter int                              WIDTH = 3,
  parameter logic [calc_depth(WIDTH)-1:0]    INIT  = 8'b0001_0010,
  parameter int                              CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             y,
  output logic             y_valid,
  input  logic             cfg_start,
  input  logic             cfg_bit,
  input  logic             cfg_valid,
  output logic             cfg_busy,
  output logic             cfg_done,
  input  logic             hit_clr
`ifdef HIT_COUNT_EN
  ,
  output logic [CNT_W-1:0] hit_count
`endif
);

  localparam int DEPTH = calc_depth(WIDTH);

  logic [DEPTH-1:0] table_r;
  logic             y_r;
  logic             y_valid_r;
  logic             commit_s;
  logic [DEPTH-1:0] new_table_s;
  logic             hit_s;

  lut_loader #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_loader (
    .clk      (clk),
    .reset_n  (reset_n),
    .cfg_start(cfg_start),
    .cfg_bit  (cfg_bit),
    .cfg_valid(cfg_valid),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
    .commit   (commit_s),
    .new_table(new_table_s)
  );

  // Lookup always uses the currently committed table, so an evaluation in
  // the commit cycle still sees the old contents.
  assign hit_s = table_r[in];

  // Committed truth table; only a full load replaces it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      table_r <= INIT;
    end else if (commit_s) begin
      table_r <= new_table_s;
    end else begin
      table_r <= table_r;
    end
  end

  // Evaluation register; y holds its last value when no input is presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_r       <= 1'b0;
      y_valid_r <= 1'b0;
    end else if (in_valid) begin
      y_r       <= hit_s;
      y_valid_r <= 1'b1;
    end else begin
      y_r       <= y_r;
      y_valid_r <= 1'b0;
    end
  end

  assign y       = y_r;
  assign y_valid = y_valid_r;

`ifdef HIT_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] hit_cnt_r;

  // Saturating hit counter; clear has priority over a simultaneous hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_r <= '0;
    end else if (hit_clr) begin
      hit_cnt_r <= '0;
    end else if (in_valid && hit_s && (hit_cnt_r != CNT_MAX)) begin
      hit_cnt_r <= hit_cnt_r + CNT_W'(1);
    end else begin
      hit_cnt_r <= hit_cnt_r;
    end
  end

  assign hit_count = hit_cnt_r;
`else
  logic [CNT_W-1:0] unused_hit_clr_s;
  assign unused_hit_clr_s = {CNT_W{hit_clr}};
`endif

endmodule

// File: tb/tb_lut_eval.sv
// tb_lut_eval: directed self-checking bench for lut_eval (default parameters).
// With HIT_COUNT_EN defined, a second instance with CNT_W = 2 checks saturation.
module tb_lut_eval;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] in = 3'd0;
  logic       in_valid = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       hit_clr = 1'b0;
  logic       y, y_valid, cfg_busy, cfg_done;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

`ifdef HIT_COUNT_EN
  logic [7:0] hit_count;
  logic [1:0] hit_count2;
  logic       y2, y_valid2, cfg_busy2, cfg_done2;
`endif

  lut_eval dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (in),
    .in_valid (in_valid),
    .y        (y),
    .y_valid  (y_valid),
    .cfg_start(cfg_start),
    .cfg_bit  (cfg_bit),
    .cfg_valid(cfg_valid),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
    .hit_clr  (hit_clr)
`ifdef HIT_COUNT_EN
    ,
    .hit_count(hit_count)
`endif
  );

`ifdef HIT_COUNT_EN
  lut_eval #(.CNT_W(2)) dut2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (in),
    .in_valid (in_valid),
    .y        (y2),
    .y_valid  (y_valid2),
    .cfg_start(cfg_start),
    .cfg_bit  (cfg_bit),
    .cfg_valid(cfg_valid),
    .cfg_busy (cfg_busy2),
    .cfg_done (cfg_done2),
    .hit_clr  (hit_clr),
    .hit_count(hit_count2)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present inputs 0..7 on consecutive cycles and check each result.
  task automatic sweep(input string tag, input logic [7:0] tbl);
    for (int k = 0; k < 8; k++) begin
      in       = 3'(k);
      in_valid = 1'b1;
      step();
      check({tag, "_y"}, 32'(y), 32'(tbl[k]));
      check({tag, "_yv"}, 32'(y_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check({tag, "_yv_low"}, 32'(y_valid), 32'd0);
  endtask

  // Full 8-bit load. restart_at >= 0 re-asserts cfg_start on that bit;
  // eval_last presents in = 1 in the commit cycle and the one after.
  task automatic do_load(input string tag, input logic [7:0] val,
                         input int restart_at, input bit eval_last);
    for (int i = 0; i < 8; i++) begin
      cfg_start = (i == 0) || (i == restart_at);
      cfg_valid = 1'b1;
      cfg_bit   = val[i];
      if (eval_last && i == 7) begin
        in       = 3'd1;
        in_valid = 1'b1;
      end
      step();
      if (i == 0) check({tag, "_busy_rise"}, 32'(cfg_busy), 32'd1);
      if (i == 6) check({tag, "_busy_hold"}, 32'(cfg_busy), 32'd1);
      if (i < 7) check({tag, "_no_done"}, 32'(cfg_done), 32'd0);
    end
    check({tag, "_done"}, 32'(cfg_done), 32'd1);
    check({tag, "_busy_fall"}, 32'(cfg_busy), 32'd0);
    if (eval_last) check({tag, "_old_table"}, 32'(y), 32'd1);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    step();
    check({tag, "_done_pulse"}, 32'(cfg_done), 32'd0);
    if (eval_last) check({tag, "_new_table"}, 32'(y), 32'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_y", 32'(y), 32'd0);
    check("rst_yv", 32'(y_valid), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
`ifdef HIT_COUNT_EN
    check("rst_hits", 32'(hit_count), 32'd0);
`endif
    reset_n = 1'b1;
    step();

    sweep("sweep_init", 8'h12);

    // cfg_valid without cfg_start is ignored in RUN
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ign_valid_busy", 32'(cfg_busy), 32'd0);
    end
    cfg_valid = 1'b0;
    step();
    check("ign_valid_done", 32'(cfg_done), 32'd0);
    sweep("sweep_ign", 8'h12);

    do_load("load_a5", 8'hA5, -1, 1'b0);
    sweep("sweep_a5", 8'hA5);

    // Reset mid-load: 4 of 8 bits, then asynchronous reset
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_bit = 1'b1;
      step();
      cfg_start = 1'b0;
    end
    cfg_valid = 1'b0;
    check("midload_busy", 32'(cfg_busy), 32'd1);
    reset_n = 1'b0;
    #2;
    check("midrst_busy", 32'(cfg_busy), 32'd0);
    check("midrst_y", 32'(y), 32'd0);
    reset_n = 1'b1;
    step();
    check("midrst_busy2", 32'(cfg_busy), 32'd0);
    sweep("sweep_midrst", 8'h12);

`ifdef HIT_COUNT_EN
    sweep("sweep_cnt2", 8'h12);
    sweep("sweep_cnt3", 8'h12);
    check("hits_3sweeps", 32'(hit_count), 32'd6);
    in       = 3'd4;
    in_valid = 1'b1;
    hit_clr  = 1'b1;
    step();
    check("hitclr_y", 32'(y), 32'd1);
    check("hitclr_wins", 32'(hit_count), 32'd0);
    hit_clr = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("hits_10", 32'(hit_count), 32'd10);
    check("hits_sat_w2", 32'(hit_count2), 32'd3);
    in_valid = 1'b0;
    step();
    check("hits_hold", 32'(hit_count), 32'd10);
`endif

    // Commit collision: old table (0x12) for in = 1, then new table (0x00)
    do_load("load_00", 8'h00, -1, 1'b1);
    sweep("sweep_00", 8'h00);

    // Second cfg_start during LOAD does not restart the index
    do_load("load_c3", 8'hC3, 3, 1'b0);
    sweep("sweep_c3", 8'hC3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
